// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake and operand/result bundle between the ALU control logic
//   (master) and the bit-serial subtractor (slave).
//
//   Signals:
//     start  master->slave  request, sampled only while the slave is idle/done
//     X      master->slave  minuend
//     Y      master->slave  subtrahend
//     Bin    master->slave  borrow-in
//     busy   slave->master  bits are being processed
//     done   slave->master  one-cycle pulse, Z/Bout (and V) valid
//     Z      slave->master  difference, held until the next completion
//     Bout   slave->master  borrow-out of the MSB
//     V      slave->master  signed overflow (only when SUB_OVERFLOW_EN is defined)
//
//   Build option: SUB_OVERFLOW_EN adds the V signal.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             V;
`endif

    modport master (
        output start,
        output X,
        output Y,
        output Bin,
        input  busy,
        input  done,
        input  Z,
`ifdef SUB_OVERFLOW_EN
        input  V,
`endif
        input  Bout
    );

    modport slave (
        input  start,
        input  X,
        input  Y,
        input  Bin,
        output busy,
        output done,
        output Z,
`ifdef SUB_OVERFLOW_EN
        output V,
`endif
        output Bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, Z = X - Y - Bin (modulo 2^WIDTH),
//   computed LSB first, one bit per clock, with a single full-subtractor cell
//   and a borrow flip-flop. Low-area SUB path of the ALU.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   serial_subtractor_if.slave (start/X/Y/Bin in, busy/done/Z/Bout/V out)
//
//   Timing: start accepted at edge t0 (in IDLE or DONE); busy is high for the
//   WIDTH cycles after t0; done pulses for one cycle after edge t0+WIDTH.
//   A start during DONE reloads immediately (no IDLE gap).
//
//   Build option: SUB_OVERFLOW_EN adds the signed-overflow output V.
//
//   States:
//     S_IDLE  | waiting for start
//     S_SHIFT | one result bit produced per clock
//     S_DONE  | one-cycle completion; Z/Bout/V just updated
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    // The minuend register doubles as the result shift register: each cycle
    // the consumed LSB leaves at the bottom and the new difference bit enters
    // at the top, so after WIDTH shifts it holds the complete difference.
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic             r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_bout;
`ifdef SUB_OVERFLOW_EN
    logic             r_xmsb;
    logic             r_ymsb;
    logic             r_v;
`endif

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_b_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_xs_next;

    // Full-subtractor cell
    assign w_x      = r_xs[0];
    assign w_y      = r_ys[0];
    assign w_d      = w_x ^ w_y ^ r_b;
    assign w_b_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_b);

    assign w_xs_next = {w_d, r_xs[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_xs    <= '0;
            r_ys    <= '0;
            r_b     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
            r_bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            r_xmsb  <= 1'b0;
            r_ymsb  <= 1'b0;
            r_v     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        r_xs    <= bus.X;
                        r_ys    <= bus.Y;
                        r_b     <= bus.Bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                        r_xmsb  <= bus.X[WIDTH-1];
                        r_ymsb  <= bus.Y[WIDTH-1];
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    r_xs <= w_xs_next;
                    r_ys <= {1'b0, r_ys[WIDTH-1:1]};
                    r_b  <= w_b_next;
                    if (w_last) begin
                        // Last bit: the MSB cell's outputs go straight into
                        // the result registers on this same edge.
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_z     <= w_xs_next;
                        r_bout  <= w_b_next;
`ifdef SUB_OVERFLOW_EN
                        // w_d is the new Z MSB
                        r_v     <= (r_xmsb ^ r_ymsb) & (r_xmsb ^ w_d);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Z    = r_z;
    assign bus.Bout = r_bout;
`ifdef SUB_OVERFLOW_EN
    assign bus.V    = r_v;
`endif

endmodule
